// File: rtl/spi_slave_pkg.sv
// ---------------------------------------------------------------------------
// spi_slave_pkg
//   Shared definitions for the SPI responder engine.
//   - SPI_SYNC_STAGES   : default synchronizer depth for the SPI pins
//   - spi_slave_state_t : responder FSM states
// ---------------------------------------------------------------------------
package spi_slave_pkg;

    localparam int SPI_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // waiting for CS_N to fall
        FETCH = 2'd1,   // request next TX byte (or substitute 0xFF)
        LOAD  = 2'd2,   // capture TX FIFO read data into the shifter
        XFER  = 2'd3    // shifting bits on SCLK edges
    } spi_slave_state_t;

endpackage

// File: rtl/spi_sync.sv
// ---------------------------------------------------------------------------
// spi_sync
//   Single-bit multi-flop synchronizer for an asynchronous input.
//   Ports:
//     clk : system clock
//     rst : synchronous active-high reset, clears every stage to 0
//     d   : asynchronous input
//     q   : synchronized output, STAGES clk cycles behind d
//   STAGES must be at least 2.
// ---------------------------------------------------------------------------
module spi_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[STAGES-2:0], d};
        end
    end

    assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// ---------------------------------------------------------------------------
// spi_slave
//   SPI responder engine. Oversamples SCLK/CS_N/MOSI in the clk domain,
//   shifts bytes MSB-first in all four CPOL/CPHA modes, reads a TX FIFO and
//   writes an RX FIFO.
//   Ports:
//     clk, rst                 : system clock, synchronous active-high reset
//     sclk_i, cs_n_i, mosi_i   : asynchronous SPI pins
//     miso_o, miso_oe_o        : serial data out and its pad enable
//     cpol_i, cpha_i           : SPI mode, captured while idle
//     tx_data_i, tx_empty_i    : TX FIFO read data (valid cycle after read), empty
//     tx_read_o                : TX FIFO read pulse
//     rx_data_o, rx_write_o    : received byte and RX FIFO write pulse
//     rx_full_i                : RX FIFO full flag
//     underrun_o, overrun_o    : error pulses (TX empty / RX full)
//     busy_o                   : high whenever not idle
// ---------------------------------------------------------------------------
module spi_slave
    import spi_slave_pkg::*;
#(
    parameter int SYNC_STAGES = SPI_SYNC_STAGES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk_i,
    input  logic       cs_n_i,
    input  logic       mosi_i,
    output logic       miso_o,
    output logic       miso_oe_o,
    input  logic       cpol_i,
    input  logic       cpha_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_empty_i,
    output logic       tx_read_o,
    output logic [7:0] rx_data_o,
    output logic       rx_write_o,
    input  logic       rx_full_i,
    output logic       underrun_o,
    output logic       overrun_o,
    output logic       busy_o
);

    // ---------------- pin synchronizers ----------------
    logic [2:0] pin_raw;
    logic [2:0] pin_sync;
    logic       sclk_s;
    logic       cs_n_s;
    logic       mosi_s;

    assign pin_raw = {mosi_i, cs_n_i, sclk_i};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sync
            spi_sync #(
                .STAGES (SYNC_STAGES)
            ) u_sync (
                .clk (clk),
                .rst (rst),
                .d   (pin_raw[gi]),
                .q   (pin_sync[gi])
            );
        end
    endgenerate

    assign sclk_s = pin_sync[0];
    assign cs_n_s = pin_sync[1];
    assign mosi_s = pin_sync[2];

    // ---------------- state ----------------
    spi_slave_state_t state_reg, state_next;
    logic       sclk_prev_reg;
    logic       cs_n_prev_reg;
    logic       cpol_reg, cpol_next;
    logic       cpha_reg, cpha_next;
    logic [7:0] tx_shift_reg, tx_shift_next;
    logic [7:0] rx_shift_reg, rx_shift_next;
    logic [2:0] bit_cnt_reg, bit_cnt_next;
    logic [7:0] rx_data_reg, rx_data_next;
    logic       rx_write_reg, rx_write_next;
    logic       overrun_reg, overrun_next;
    logic       underrun_reg, underrun_next;
    logic       fetch_read;

    // ---------------- edge classification ----------------
    logic sclk_edge;
    logic lead_edge;
    logic trail_edge;
    logic sample_edge;
    logic shift_edge;
    logic cs_fall;

    // Leading edge leaves the idle level (cpol), trailing edge returns to it.
    assign sclk_edge   = sclk_s ^ sclk_prev_reg;
    assign lead_edge   = sclk_edge && (sclk_s != cpol_reg);
    assign trail_edge  = sclk_edge && (sclk_s == cpol_reg);
    assign sample_edge = cpha_reg ? trail_edge : lead_edge;
    assign shift_edge  = cpha_reg ? lead_edge  : trail_edge;
    assign cs_fall     = cs_n_prev_reg && !cs_n_s;

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            sclk_prev_reg <= 1'b0;
            cs_n_prev_reg <= 1'b0;
            cpol_reg      <= 1'b0;
            cpha_reg      <= 1'b0;
            tx_shift_reg  <= 8'h00;
            rx_shift_reg  <= 8'h00;
            bit_cnt_reg   <= 3'd0;
            rx_data_reg   <= 8'h00;
            rx_write_reg  <= 1'b0;
            overrun_reg   <= 1'b0;
            underrun_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            sclk_prev_reg <= sclk_s;
            cs_n_prev_reg <= cs_n_s;
            cpol_reg      <= cpol_next;
            cpha_reg      <= cpha_next;
            tx_shift_reg  <= tx_shift_next;
            rx_shift_reg  <= rx_shift_next;
            bit_cnt_reg   <= bit_cnt_next;
            rx_data_reg   <= rx_data_next;
            rx_write_reg  <= rx_write_next;
            overrun_reg   <= overrun_next;
            underrun_reg  <= underrun_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_next    = state_reg;
        cpol_next     = cpol_reg;
        cpha_next     = cpha_reg;
        tx_shift_next = tx_shift_reg;
        rx_shift_next = rx_shift_reg;
        bit_cnt_next  = bit_cnt_reg;
        rx_data_next  = rx_data_reg;
        rx_write_next = 1'b0;
        overrun_next  = 1'b0;
        underrun_next = 1'b0;
        fetch_read    = 1'b0;

        case (state_reg)
            IDLE: begin
                // Mode is tracked only while idle so it is frozen for the transfer.
                cpol_next     = cpol_i;
                cpha_next     = cpha_i;
                bit_cnt_next  = 3'd0;
                rx_shift_next = 8'h00;
                if (cs_fall) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                if (!tx_empty_i) begin
                    fetch_read = 1'b1;
                    state_next = LOAD;
                end else begin
                    tx_shift_next = 8'hFF;
                    underrun_next = 1'b1;
                    state_next    = XFER;
                end
            end
            LOAD: begin
                tx_shift_next = tx_data_i;
                state_next    = XFER;
            end
            XFER: begin
                if (sample_edge) begin
                    rx_shift_next = {rx_shift_reg[6:0], mosi_s};
                    bit_cnt_next  = bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7) begin
                        if (!rx_full_i) begin
                            rx_data_next  = {rx_shift_reg[6:0], mosi_s};
                            rx_write_next = 1'b1;
                        end else begin
                            overrun_next = 1'b1;
                        end
                        // Prefetch the next TX byte straight away.
                        state_next = FETCH;
                    end
                end else if (shift_edge && (bit_cnt_reg != 3'd0)) begin
                    // bit_cnt==0 shift edges are the CPHA=1 opening edge or the
                    // CPHA=0 closing edge of a byte; neither should move data.
                    tx_shift_next = {tx_shift_reg[6:0], 1'b1};
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Deselect aborts anything in flight and wins over a same-cycle SCLK edge.
        // A read already issued in FETCH still happens: that byte is discarded.
        if ((state_reg != IDLE) && cs_n_s) begin
            state_next    = IDLE;
            bit_cnt_next  = 3'd0;
            rx_shift_next = 8'h00;
            rx_write_next = 1'b0;
            overrun_next  = 1'b0;
            underrun_next = 1'b0;
        end
    end

    // ---------------- outputs ----------------
    // The pad stays driven through FETCH/LOAD so MISO does not float between
    // back-to-back bytes.
    assign busy_o     = (state_reg != IDLE);
    assign miso_oe_o  = busy_o;
    assign miso_o     = miso_oe_o ? tx_shift_reg[7] : 1'b0;
    assign tx_read_o  = fetch_read && !rst;
    assign rx_data_o  = rx_data_reg;
    assign rx_write_o = rx_write_reg;
    assign overrun_o  = overrun_reg;
    assign underrun_o = underrun_reg;

endmodule

// File: tb/tb_spi_slave.sv
// ---------------------------------------------------------------------------
// tb_spi_slave
//   Directed bench for spi_slave: an SPI master model drives the pins, small
//   TX/RX FIFO models sit on the FIFO side, and pulse counters watch the
//   single-cycle outputs.
// ---------------------------------------------------------------------------
module tb_spi_slave;

    localparam int HALF  = 8;   // SCLK half period in clk cycles
    localparam int SETUP = 8;   // CS_N fall to first leading edge margin

    logic       clk = 1'b0;
    logic       rst;
    logic       sclk;
    logic       cs_n;
    logic       mosi;
    logic       miso;
    logic       miso_oe;
    logic       cpol;
    logic       cpha;
    logic [7:0] tx_data = 8'h00;
    logic       tx_empty;
    logic       tx_read;
    logic [7:0] rx_data;
    logic       rx_write;
    logic       rx_full;
    logic       underrun;
    logic       overrun;
    logic       busy;

    always #5 clk = ~clk;

    spi_slave #(
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sclk_i     (sclk),
        .cs_n_i     (cs_n),
        .mosi_i     (mosi),
        .miso_o     (miso),
        .miso_oe_o  (miso_oe),
        .cpol_i     (cpol),
        .cpha_i     (cpha),
        .tx_data_i  (tx_data),
        .tx_empty_i (tx_empty),
        .tx_read_o  (tx_read),
        .rx_data_o  (rx_data),
        .rx_write_o (rx_write),
        .rx_full_i  (rx_full),
        .underrun_o (underrun),
        .overrun_o  (overrun),
        .busy_o     (busy)
    );

    // ---------------- FIFO models (act on the clock edge like real FIFOs) ----
    logic [7:0] tx_mem [0:31];
    logic [7:0] rx_log [0:31];
    int tx_wr = 0;
    int tx_rd = 0;
    int rx_wr = 0;

    assign tx_empty = (tx_wr == tx_rd);

    always @(posedge clk) begin
        if (tx_read) begin
            tx_data <= tx_mem[tx_rd];
            tx_rd   <= tx_rd + 1;
        end
        if (rx_write) begin
            rx_log[rx_wr] <= rx_data;
            rx_wr         <= rx_wr + 1;
        end
    end

    // ---------------- pulse counters (sampled on the falling edge) ----------
    int n_read  = 0;
    int n_write = 0;
    int n_under = 0;
    int n_over  = 0;
    int n_b2b   = 0;
    logic prev_read  = 1'b0;
    logic prev_write = 1'b0;

    always @(negedge clk) begin
        if (tx_read)  n_read  <= n_read + 1;
        if (rx_write) n_write <= n_write + 1;
        if (underrun) n_under <= n_under + 1;
        if (overrun)  n_over  <= n_over + 1;
        if ((tx_read && prev_read) || (rx_write && prev_write)) n_b2b <= n_b2b + 1;
        prev_read  <= tx_read;
        prev_write <= rx_write;
    end

    // ---------------- checking ----------------
    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- master model ----------------
    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_tx(input logic [7:0] b);
        tx_mem[tx_wr] = b;
        tx_wr++;
    endtask

    task automatic set_mode(input logic pol, input logic pha);
        cpol = pol;
        cpha = pha;
        sclk = pol;
        wait_clk(4);
    endtask

    task automatic cs_begin();
        cs_n = 1'b0;
        wait_clk(SETUP);
    endtask

    task automatic cs_end();
        wait_clk(HALF);
        cs_n = 1'b1;
        wait_clk(2 * HALF);
    endtask

    // Shift the top nbits of mo out on MOSI, capture MISO into mi.
    task automatic shift_bits(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            if (!cpha) begin
                mosi = mo[i];
                wait_clk(HALF);
                mi[i] = miso;
                sclk  = ~cpol;
                wait_clk(HALF);
                sclk  = cpol;
            end else begin
                wait_clk(HALF);
                sclk = ~cpol;
                mosi = mo[i];
                wait_clk(HALF);
                mi[i] = miso;
                sclk  = cpol;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] mi;
        int r0, w0, u0, o0, x0;

        rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
        cpol = 1'b0; cpha = 1'b0; rx_full = 1'b0;
        wait_clk(3);
        rst = 1'b0;
        wait_clk(2);

        // Reset state
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_oe", {31'd0, miso_oe}, 32'd0);
        check("rst_miso", {31'd0, miso}, 32'd0);
        check("rst_rx_data", {24'd0, rx_data}, 32'd0);
        check("rst_pulses", {28'd0, tx_read, rx_write, underrun, overrun}, 32'd0);

        // Mode 0: TX 0xA5 (plus one prefetch byte), master sends 0x3C
        set_mode(1'b0, 1'b0);
        push_tx(8'hA5); push_tx(8'h00);
        r0 = n_read; w0 = n_write; u0 = n_under; x0 = rx_wr;
        cs_begin();
        check("m0_busy", {31'd0, busy}, 32'd1);
        check("m0_oe", {31'd0, miso_oe}, 32'd1);
        check("m0_msb", {31'd0, miso}, 32'd1);
        shift_bits(8'h3C, 8, mi);
        cs_end();
        check("m0_miso", {24'd0, mi}, 32'hA5);
        check("m0_rx_data", {24'd0, rx_data}, 32'h3C);
        check("m0_rx_log", {24'd0, rx_log[x0]}, 32'h3C);
        check("m0_writes", n_write - w0, 32'd1);
        check("m0_reads", n_read - r0, 32'd2);
        check("m0_underrun", n_under - u0, 32'd0);
        check("m0_idle_oe", {31'd0, miso_oe}, 32'd0);

        // Mode 3: back-to-back bytes
        set_mode(1'b1, 1'b1);
        push_tx(8'h11); push_tx(8'h22); push_tx(8'h33);
        w0 = n_write; x0 = rx_wr;
        cs_begin();
        shift_bits(8'h81, 8, mi);
        check("m3_miso0", {24'd0, mi}, 32'h11);
        shift_bits(8'h7E, 8, mi);
        check("m3_miso1", {24'd0, mi}, 32'h22);
        cs_end();
        check("m3_rx0", {24'd0, rx_log[x0]}, 32'h81);
        check("m3_rx1", {24'd0, rx_log[x0 + 1]}, 32'h7E);
        check("m3_writes", n_write - w0, 32'd2);

        // Underrun: TX FIFO empty at CS fall; refilled before the prefetch
        set_mode(1'b0, 1'b0);
        u0 = n_under; r0 = n_read;
        cs_begin();
        push_tx(8'h55);
        shift_bits(8'h96, 8, mi);
        cs_end();
        check("ur_miso", {24'd0, mi}, 32'hFF);
        check("ur_count", n_under - u0, 32'd1);
        check("ur_prefetch", n_read - r0, 32'd1);
        check("ur_rx_data", {24'd0, rx_data}, 32'h96);

        // Overrun: RX FIFO full at completion
        push_tx(8'h66); push_tx(8'h77);
        rx_full = 1'b1;
        w0 = n_write; o0 = n_over;
        cs_begin();
        shift_bits(8'hC3, 8, mi);
        cs_end();
        rx_full = 1'b0;
        check("ov_miso", {24'd0, mi}, 32'h66);
        check("ov_writes", n_write - w0, 32'd0);
        check("ov_count", n_over - o0, 32'd1);
        check("ov_rx_kept", {24'd0, rx_data}, 32'h96);

        // Mode 1: CS_N rises after 5 bits, then a full byte
        set_mode(1'b0, 1'b1);
        push_tx(8'hA1); push_tx(8'hB2); push_tx(8'hC3);
        w0 = n_write; x0 = rx_wr;
        cs_begin();
        shift_bits(8'hF0, 5, mi);
        wait_clk(4);
        cs_n = 1'b1;
        wait_clk(4);
        check("ab_busy", {31'd0, busy}, 32'd0);
        check("ab_oe", {31'd0, miso_oe}, 32'd0);
        check("ab_writes", n_write - w0, 32'd0);
        wait_clk(2 * HALF);
        cs_begin();
        shift_bits(8'hE7, 8, mi);
        cs_end();
        check("ab_next_miso", {24'd0, mi}, 32'hB2);
        check("ab_next_rx", {24'd0, rx_log[x0]}, 32'hE7);
        check("ab_next_writes", n_write - w0, 32'd1);

        // Reset for 2 cycles in the middle of a transfer
        set_mode(1'b0, 1'b0);
        push_tx(8'hD4); push_tx(8'hE5);
        cs_begin();
        shift_bits(8'h0F, 3, mi);
        rst = 1'b1;
        wait_clk(2);
        check("mr_busy", {31'd0, busy}, 32'd0);
        check("mr_oe_miso", {30'd0, miso_oe, miso}, 32'd0);
        check("mr_rx_data", {24'd0, rx_data}, 32'd0);
        check("mr_pulses", {28'd0, tx_read, rx_write, underrun, overrun}, 32'd0);
        rst  = 1'b0;
        cs_n = 1'b1;
        wait_clk(2 * HALF);
        w0 = n_write; x0 = rx_wr;
        cs_begin();
        shift_bits(8'h5A, 8, mi);
        cs_end();
        check("mr_next_miso", {24'd0, mi}, 32'hE5);
        check("mr_next_rx", {24'd0, rx_log[x0]}, 32'h5A);
        check("mr_next_writes", n_write - w0, 32'd1);

        check("no_back_to_back", n_b2b, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
# spi_slave

SPI responder (peripheral-side) engine: the far end of the link driven by the team's SPI master. Oversamples SCLK/CS_N/MOSI in the system clock domain, shifts bytes MSB-first in all four CPOL/CPHA modes, drives MISO, and connects to two `spi_fifo` instances: a TX FIFO it reads and an RX FIFO it writes. Sits between the pad ring and the SPI register/FIFO layer.

## Interface
- `SYNC_STAGES`, 2: synchronizer depth for `sclk_i`, `cs_n_i` and `mosi_i`; minimum 2.
- `clk` input 1: system clock. Only clock.
- `rst` input 1: reset, synchronous, active-high.
- `sclk_i`, `cs_n_i`, `mosi_i` input 1 each: asynchronous SPI pins.
- `miso_o` output 1: serial data out.
- `miso_oe_o` output 1: MISO pad output enable.
- `cpol_i`, `cpha_i` input 1 each: mode select. Sampled only in IDLE.
- `tx_data_i` input 8: TX FIFO `out_data_o`. Valid the cycle after `tx_read_o`.
- `tx_empty_i` input 1: TX FIFO empty flag.
- `tx_read_o` output 1: single-cycle TX FIFO read pulse.
- `rx_data_o` output 8: received byte, wired to RX FIFO `in_data_i`.
- `rx_write_o` output 1: single-cycle RX FIFO write pulse.
- `rx_full_i` input 1: RX FIFO full flag.
- `underrun_o`, `overrun_o` output 1 each: single-cycle error pulses.
- `busy_o` output 1: high whenever state ≠ IDLE.

## Operation
- Inputs pass through `SYNC_STAGES` flops. SCLK edge detection compares the last two synced samples.
- Leading edge: transition away from `cpol_i`. Trailing edge: transition back.
- Sample edge is leading when `cpha_i`=0, trailing when `cpha_i`=1. Shift edge is the other one.
- States:
  - IDLE: `miso_oe_o`=0. Synced CS_N falling moves to FETCH.
  - FETCH: if `!tx_empty_i`, pulse `tx_read_o` and go to LOAD. Otherwise load 0xFF into `tx_shift`, pulse `underrun_o` and go to XFER.
  - LOAD: `tx_shift <= tx_data_i`, go to XFER.
  - XFER: `miso_oe_o`=1, `miso_o = tx_shift[7]`.
- XFER sample edge: `rx_shift <= {rx_shift[6:0], mosi_s}`, `bit_cnt` increments (3-bit, wraps 7→0).
- XFER shift edge with `bit_cnt` ≠ 0: `tx_shift <= {tx_shift[6:0], 1'b1}`. Shift edges with `bit_cnt`==0 are ignored; this covers the CPHA=1 first edge and the CPHA=0 post-byte trailing edge.
- Byte completion (sample edge with `bit_cnt`==7):
  - If `!rx_full_i`: `rx_data_o` ← assembled byte and `rx_write_o` pulses.
  - Otherwise `overrun_o` pulses; the byte is dropped and `rx_data_o` is unchanged.
  - Either way, state goes to FETCH to prefetch the next TX byte.
- Prefetch is unconditional: if CS_N rises after completion, the prefetched byte is consumed and discarded.
- Synced CS_N high in any non-IDLE state → IDLE next cycle:
  - Partial byte discarded, no `rx_write_o`.
  - `bit_cnt` and `rx_shift` cleared.
  - CS_N has priority over a same-cycle SCLK edge.
- `rst` has priority over everything. It forces IDLE and clears all outputs to 0, including `rx_data_o` and `miso_o`, plus `bit_cnt` and both shift registers. Reset mid-transfer abandons the byte.

## Timing
- Edge detected SYNC_STAGES+1 clk after the pin edge. `rx_write_o`/`overrun_o` are registered and assert one cycle after detection.
- FETCH→LOAD→XFER takes 2 clk; FETCH→XFER on underrun takes 1 clk.
- Master constraints:
  - SCLK half-period ≥ SYNC_STAGES+4 clk.
  - CS_N fall to first SCLK edge ≥ SYNC_STAGES+4 clk, so MISO MSB is valid before the first sample in CPHA=0.
- `tx_read_o` and `rx_write_o` are never high for two consecutive cycles. At most one of each per byte.

## Structure
- Add a `spi_slave_state_t` enum (IDLE, FETCH, LOAD, XFER) and an `SPI_SYNC_STAGES` default constant to `spi_defs.svh`, alongside `DEPTH_FIFO`/`ADDR_FIFO`.
- One sub-module, `spi_sync`: a parameterized multi-flop synchronizer, instantiated three times.

## Test plan
- Reset: assert `rst` 2 cycles mid-XFER → all outputs 0, `busy_o`=0, next transfer starts at bit 7 cleanly.
- Mode 0, TX FIFO holds 0xA5, master sends 0x3C:
  - MISO samples 1,0,1,0,0,1,0,1.
  - `rx_data_o`=0x3C with one `rx_write_o`.
  - `tx_read_o` pulses twice: initial fetch plus prefetch.
- Mode 3, TX 0x11,0x22, master sends 0x81,0x7E back-to-back → MISO 0x11 then 0x22. RX writes 0x81 then 0x7E.
- `tx_empty_i`=1 at CS fall → MISO shifts 0xFF and `underrun_o` pulses once.
- `rx_full_i`=1 at completion → no `rx_write_o`, one `overrun_o`, `rx_data_o` keeps its old value.
- CS_N rises after 5 bits (mode 1) → no RX write, `busy_o` low within SYNC_STAGES+2 clk, `miso_oe_o`=0. The next byte is received intact.
